// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge stage.
package sobel_pkg;

    localparam int COLORDEPTH_DEF = 8;
    localparam int SOBEL_LAT      = 3;
    localparam int MAX_CD         = 16;

    function automatic int grad_w(input int cd);
        return cd + 3;
    endfunction

    typedef logic signed [grad_w(COLORDEPTH_DEF)-1:0] grad_t;

    // Clamp an unsigned value to the largest cd-bit number.
    function automatic logic [MAX_CD+2:0] sat_u(input logic [MAX_CD+2:0] v, input int cd);
        logic [MAX_CD+2:0] lim;
        lim = {(MAX_CD+3){1'b1}} >> (MAX_CD + 3 - cd);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sobel_window.sv
// 3x3 pixel window built from three vertical taps, plus the column-fill
// counter that says when all three columns hold pixels of the current run.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int CD = COLORDEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CD-1:0]          px_line_n2_i,
    input  logic [CD-1:0]          px_line_n1_i,
    input  logic [CD-1:0]          px_line_n0_i,
    input  logic                   dv_i,
    output logic [2:0][2:0][CD-1:0] win_o,     // [row][col], row 0 = top, col 0 = newest
    output logic                   win_ok_o
);

    logic [2:0][2:0][CD-1:0] win_q, win_d;
    logic [1:0]              col_cnt_q, col_cnt_d;
    logic                    win_ok_q, win_ok_d;

    always_comb begin
        win_d     = win_q;
        col_cnt_d = 2'd0;
        win_ok_d  = dv_i && (col_cnt_q == 2'd2);
        if (dv_i) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][1];
                win_d[r][1] = win_q[r][0];
            end
            win_d[0][0] = px_line_n2_i;
            win_d[1][0] = px_line_n1_i;
            win_d[2][0] = px_line_n0_i;
            col_cnt_d   = (col_cnt_q == 2'd2) ? 2'd2 : col_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q     <= '0;
            col_cnt_q <= 2'd0;
            win_ok_q  <= 1'b0;
        end else begin
            win_q     <= win_d;
            col_cnt_q <= col_cnt_d;
            win_ok_q  <= win_ok_d;
        end
    end

    assign win_o    = win_q;
    assign win_ok_o = win_ok_q;

endmodule

// File: rtl/sobel_kernel.sv
// Sobel edge stage: window (S1), Gx/Gy (S2), |Gx|+|Gy| scale/saturate/threshold (S3).
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int COLORDEPTH = COLORDEPTH_DEF,
    parameter int SHIFT      = 0,
    parameter int BINARY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_line_n2_i,
    input  logic [COLORDEPTH-1:0] px_line_n1_i,
    input  logic [COLORDEPTH-1:0] px_line_n0_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic [COLORDEPTH-1:0] thresh_i,
    output logic [COLORDEPTH-1:0] edge_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    localparam int GW = grad_w(COLORDEPTH);
    typedef logic signed [GW-1:0] sgrad_t;

    logic [2:0][2:0][COLORDEPTH-1:0] win;
    logic                            win_ok;

    sobel_window #(.CD(COLORDEPTH)) u_window (
        .clk          (clk),
        .rst          (rst),
        .px_line_n2_i (px_line_n2_i),
        .px_line_n1_i (px_line_n1_i),
        .px_line_n0_i (px_line_n0_i),
        .dv_i         (dv_i),
        .win_o        (win),
        .win_ok_o     (win_ok)
    );

    // Bit i of each pipe is the sync belonging to stage S(i+1).
    logic [SOBEL_LAT-1:0] dv_pipe_q, dv_pipe_d;
    logic [SOBEL_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [SOBEL_LAT-1:0] vs_pipe_q, vs_pipe_d;
    sgrad_t               gx_q, gx_d, gy_q, gy_d;
    logic                 ok2_q, ok2_d;
    logic [COLORDEPTH-1:0] edge_q, edge_d;

    logic [GW-1:0] col_r, col_l, row_b, row_t;
    logic [GW-1:0] abs_x, abs_y, mag, scaled;
    logic [COLORDEPTH-1:0] sat;

    always_comb begin
        dv_pipe_d = {dv_pipe_q[SOBEL_LAT-2:0], dv_i};
        hs_pipe_d = {hs_pipe_q[SOBEL_LAT-2:0], hs_i};
        vs_pipe_d = {vs_pipe_q[SOBEL_LAT-2:0], vs_i};

        // S2: gradients; kernel weights 1-2-1 along columns (Gx) and rows (Gy)
        col_r = GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]);
        col_l = GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]);
        row_b = GW'(win[2][2]) + (GW'(win[2][1]) << 1) + GW'(win[2][0]);
        row_t = GW'(win[0][2]) + (GW'(win[0][1]) << 1) + GW'(win[0][0]);
        gx_d  = sgrad_t'(col_r - col_l);
        gy_d  = sgrad_t'(row_b - row_t);
        ok2_d = win_ok;

        // S3: magnitude cannot overflow GW bits (max 8*(2^CD-1))
        abs_x  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_y  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag    = abs_x + abs_y;
        scaled = mag >> SHIFT;
        sat    = COLORDEPTH'(sat_u((MAX_CD+3)'(scaled), COLORDEPTH));

        edge_d = '0;
        if (dv_pipe_q[1] && ok2_q) begin
            edge_d = (BINARY != 0) ? {COLORDEPTH{sat >= thresh_i}} : sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_pipe_q <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            ok2_q     <= 1'b0;
            edge_q    <= '0;
        end else begin
            dv_pipe_q <= dv_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            ok2_q     <= ok2_d;
            edge_q    <= edge_d;
        end
    end

    assign edge_o = edge_q;
    assign dv_o   = dv_pipe_q[SOBEL_LAT-1];
    assign hs_o   = hs_pipe_q[SOBEL_LAT-1];
    assign vs_o   = vs_pipe_q[SOBEL_LAT-1];

endmodule
